// File: rtl/seq_detect_ctrl_if.sv
// seq_detect_ctrl_if: config, stream and status bundle for seq_detect_ctrl.
// Optional timeout signals are present when SEQ_DETECT_TIMEOUT_EN is defined.
interface seq_detect_ctrl_if #(
  parameter int MAXLEN = 8,
  parameter int LENW   = 4,
  parameter int CNTW   = 8,
  parameter int TOW    = 16
);
  logic              cfg_we;
  logic [MAXLEN-1:0] cfg_pattern;
  logic [LENW-1:0]   cfg_len;
  logic              cfg_overlap;
  logic [CNTW-1:0]   cfg_target;
  logic              start;
  logic              stop;
  logic              in_valid;
  logic              in;
  logic              busy;
  logic              match;
  logic              done;
  logic [CNTW-1:0]   match_count;
`ifdef SEQ_DETECT_TIMEOUT_EN
  logic [TOW-1:0]    cfg_timeout;
  logic              timeout;
`endif

  modport master (
`ifdef SEQ_DETECT_TIMEOUT_EN
    output cfg_timeout,
    input  timeout,
`endif
    output cfg_we, cfg_pattern, cfg_len,
    output cfg_overlap, cfg_target,
    output start, stop, in_valid, in,
    input  busy, match, done, match_count
  );

  modport slave (
`ifdef SEQ_DETECT_TIMEOUT_EN
    input  cfg_timeout,
    output timeout,
`endif
    input  cfg_we, cfg_pattern, cfg_len,
    input  cfg_overlap, cfg_target,
    input  start, stop, in_valid, in,
    output busy, match, done, match_count
  );
endinterface

// File: rtl/seq_detect_ctrl.sv
// seq_detect_ctrl: programmable serial pattern detector session controller.
// Define SEQ_DETECT_TIMEOUT_EN to add the inactivity timeout.
module seq_detect_ctrl #(
  parameter int MAXLEN = 8,
  parameter int LENW   = 4,
  parameter int CNTW   = 8,
  parameter int TOW    = 16
) (
  input logic clk,
  input logic rst,
  seq_detect_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [LENW-1:0] LMAX = LENW'(MAXLEN);

  state_t            state;
  state_t            nstate;
  logic [MAXLEN-1:0] pat;
  logic [LENW-1:0]   len;
  logic              ovl;
  logic [CNTW-1:0]   tgt;
  logic [MAXLEN-2:0] hist;
  logic [LENW-1:0]   fill;
  logic [CNTW-1:0]   cnt;
  logic              match_r;

  logic [LENW-1:0]   len_in;
  logic [MAXLEN-1:0] shifted;
  logic [MAXLEN-1:0] mask;
  logic [LENW:0]     fill_inc;
  logic [CNTW-1:0]   cnt_inc;
  logic              run;
  logic              beat;
  logic              hit;
  logic              tgt_hit;
  logic              to_hit;
  logic              cfg_ok;
  logic              arm;

`ifdef SEQ_DETECT_TIMEOUT_EN
  logic [TOW-1:0]    tmo;
  logic [TOW-1:0]    to_cnt;
  logic [TOW-1:0]    to_nxt;
  logic              to_flag;
`endif

  // Match evaluation for the beat presented this cycle
  always_comb begin
    len_in = bus.cfg_len;
    if (bus.cfg_len == '0 || bus.cfg_len > LMAX)
      len_in = LMAX;
    shifted  = {hist, bus.in};
    fill_inc = {1'b0, fill} + 1'b1;
    for (int i = 0; i < MAXLEN; i++)
      mask[i] = (i < int'(len));
    cnt_inc  = (&cnt) ? cnt : cnt + 1'b1;
    run      = (state == S_RUN);
    beat     = run && bus.in_valid && !bus.stop;
    hit      = beat
            && (fill_inc >= {1'b0, len})
            && (((shifted ^ pat) & mask) == '0);
    tgt_hit  = hit && (tgt != '0) && (cnt_inc == tgt);
    cfg_ok   = (state == S_IDLE) && bus.cfg_we;
    arm      = (state != S_RUN) && bus.start;
  end

`ifdef SEQ_DETECT_TIMEOUT_EN
  // Inactivity counter compare; a match restarts the count
  always_comb begin
    to_nxt = hit ? '0 : to_cnt + 1'b1;
    to_hit = run && !bus.stop
          && (tmo != '0) && (to_nxt == tmo);
  end
`else
  assign to_hit = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= nstate;
  end

  // Next-state logic; stop outranks a beat in RUN
  always_comb begin
    nstate = state;
    case (state)
      S_IDLE: if (bus.start) nstate = S_RUN;
      S_RUN: begin
        if (bus.stop)
          nstate = S_IDLE;
        else if (tgt_hit || to_hit)
          nstate = S_DONE;
      end
      S_DONE: begin
        if (bus.start)
          nstate = S_RUN;
        else if (bus.stop)
          nstate = S_IDLE;
      end
      default: nstate = S_IDLE;
    endcase
  end

  // Outputs decoded from state plus registered datapath
  always_comb begin
    bus.busy        = (state == S_RUN);
    bus.done        = (state == S_DONE);
    bus.match       = match_r;
    bus.match_count = cnt;
`ifdef SEQ_DETECT_TIMEOUT_EN
    bus.done        = (state == S_DONE) && !to_flag;
    bus.timeout     = to_flag;
`endif
  end

  // Config latch, history, fill, match pulse and counter
  always_ff @(posedge clk) begin
    if (rst) begin
      pat     <= '0;
      len     <= LMAX;
      ovl     <= 1'b1;
      tgt     <= '0;
      hist    <= '0;
      fill    <= '0;
      cnt     <= '0;
      match_r <= 1'b0;
    end else begin
      match_r <= hit;
      if (cfg_ok) begin
        pat <= bus.cfg_pattern;
        len <= len_in;
        ovl <= bus.cfg_overlap;
        tgt <= bus.cfg_target;
      end
      if (arm) begin
        hist <= '0;
        fill <= '0;
        cnt  <= '0;
      end else if (beat) begin
        hist <= shifted[MAXLEN-2:0];
        if (hit && !ovl)
          fill <= '0;
        else if (fill_inc >= {1'b0, len})
          fill <= len;
        else
          fill <= fill_inc[LENW-1:0];
        if (hit)
          cnt <= cnt_inc;
      end
    end
  end

`ifdef SEQ_DETECT_TIMEOUT_EN
  // Timeout limit, counter and sticky flag
  always_ff @(posedge clk) begin
    if (rst) begin
      tmo     <= '0;
      to_cnt  <= '0;
      to_flag <= 1'b0;
    end else begin
      if (cfg_ok)
        tmo <= bus.cfg_timeout;
      if (arm) begin
        to_cnt  <= '0;
        to_flag <= 1'b0;
      end else if (run) begin
        to_cnt <= to_nxt;
        if (to_hit && !tgt_hit)
          to_flag <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// tb_seq_detect_ctrl: directed vectors for seq_detect_ctrl.
// Timeout vectors run when SEQ_DETECT_TIMEOUT_EN is defined.
module tb_seq_detect_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   nvec = 0;
  int   nerr = 0;
  logic [31:0] mv;
  logic [31:0] gv;

  seq_detect_ctrl_if #(
    .MAXLEN(8), .LENW(4), .CNTW(8), .TOW(16)
  ) bus ();

  seq_detect_ctrl #(
    .MAXLEN(8), .LENW(4), .CNTW(8), .TOW(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic b);
    bus.in_valid = 1'b1;
    bus.in       = b;
    tick();
    bus.in_valid = 1'b0;
    bus.in       = 1'b0;
  endtask

  // bits[n-1] goes first; mv[i] = match after beat i+1
  task automatic stream(input logic [31:0] bits, input int n,
                        input bit gap,
                        output logic [31:0] m,
                        output logic [31:0] g);
    m = '0;
    g = '0;
    for (int i = 0; i < n; i++) begin
      beat(bits[n-1-i]);
      m[i] = bus.match;
      if (gap) begin
        tick();
        g[i] = bus.match;
      end
    end
  endtask

  task automatic cfg(input logic [7:0] p, input logic [3:0] l,
                     input logic o, input logic [7:0] t,
                     input logic [15:0] to);
    bus.stop = 1'b1;
    tick();
    bus.stop        = 1'b0;
    bus.cfg_pattern = p;
    bus.cfg_len     = l;
    bus.cfg_overlap = o;
    bus.cfg_target  = t;
`ifdef SEQ_DETECT_TIMEOUT_EN
    bus.cfg_timeout = to;
`else
    if (to != 16'd0) $display("note: timeout ignored");
`endif
    bus.cfg_we = 1'b1;
    bus.start  = 1'b1;
    tick();
    bus.cfg_we = 1'b0;
    bus.start  = 1'b0;
  endtask

  initial begin
    bus.cfg_we = 0; bus.cfg_pattern = 0; bus.cfg_len = 0;
    bus.cfg_overlap = 0; bus.cfg_target = 0;
    bus.start = 0; bus.stop = 0; bus.in_valid = 0; bus.in = 0;
`ifdef SEQ_DETECT_TIMEOUT_EN
    bus.cfg_timeout = 0;
`endif
    tick(); tick();
    check("rst_busy", bus.busy, 0);
    check("rst_match", bus.match, 0);
    check("rst_done", bus.done, 0);
    check("rst_cnt", bus.match_count, 0);
    rst = 1'b0;
    tick();

    // overlapping 11011
    cfg(8'h1B, 4'd5, 1'b1, 8'd0, 16'd0);
    check("s1_busy0", bus.busy, 1);
    stream(32'b11011011, 8, 1'b0, mv, gv);
    check("s1_match", mv, 32'h90);
    check("s1_cnt", bus.match_count, 2);
    check("s1_busy", bus.busy, 1);

    // non-overlapping
    cfg(8'h1B, 4'd5, 1'b0, 8'd0, 16'd0);
    stream(32'b11011011, 8, 1'b0, mv, gv);
    check("s2_match8", mv, 32'h10);
    check("s2_cnt8", bus.match_count, 1);
    stream(32'b011, 3, 1'b0, mv, gv);
    check("s2_match11", mv, 32'h4);
    check("s2_cnt11", bus.match_count, 2);

    // target 3
    cfg(8'h1B, 4'd5, 1'b1, 8'd3, 16'd0);
    stream(32'b11011011011, 11, 1'b0, mv, gv);
    check("s3_match", mv, 32'h490);
    check("s3_done", bus.done, 1);
    check("s3_busy", bus.busy, 0);
    stream(32'b11, 2, 1'b0, mv, gv);
    check("s3_cnt", bus.match_count, 3);
    check("s3_nomatch", mv, 0);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("s3_restart_busy", bus.busy, 1);
    check("s3_restart_cnt", bus.match_count, 0);
    check("s3_restart_done", bus.done, 0);

    // gaps between beats
    cfg(8'h1B, 4'd5, 1'b1, 8'd0, 16'd0);
    stream(32'b11011011, 8, 1'b1, mv, gv);
    check("s4_match", mv, 32'h90);
    check("s4_gap", gv, 0);
    check("s4_cnt", bus.match_count, 2);

    // stop beats completing beat
    cfg(8'h1B, 4'd5, 1'b1, 8'd0, 16'd0);
    stream(32'b1101, 4, 1'b0, mv, gv);
    bus.stop = 1'b1;
    beat(1'b1);
    bus.stop = 1'b0;
    check("s5_match", bus.match, 0);
    check("s5_busy", bus.busy, 0);
    check("s5_cnt", bus.match_count, 0);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("s5_rearm", bus.busy, 1);
    stream(32'b1101, 4, 1'b0, mv, gv);
    rst = 1'b1;
    beat(1'b1);
    check("s5_rst_busy", bus.busy, 0);
    check("s5_rst_match", bus.match, 0);
    check("s5_rst_done", bus.done, 0);
    check("s5_rst_cnt", bus.match_count, 0);
    rst = 1'b0;
    tick();

    // len=1, non-overlap
    cfg(8'h01, 4'd1, 1'b0, 8'd0, 16'd0);
    stream(32'b1011, 4, 1'b0, mv, gv);
    check("len1_match", mv, 32'hD);
    check("len1_cnt", bus.match_count, 3);

    // len=0 clamps to 8
    cfg(8'hA5, 4'd0, 1'b1, 8'd0, 16'd0);
    stream(32'hA5, 8, 1'b0, mv, gv);
    check("len0_match", mv, 32'h80);

    // len=12 clamps to 8
    cfg(8'hA5, 4'd12, 1'b1, 8'd0, 16'd0);
    stream(32'hA5, 8, 1'b0, mv, gv);
    check("len12_match", mv, 32'h80);

    // counter saturation
    cfg(8'h01, 4'd1, 1'b1, 8'd0, 16'd0);
    for (int i = 0; i < 260; i++) beat(1'b1);
    check("sat_cnt", bus.match_count, 255);
    check("sat_busy", bus.busy, 1);

`ifdef SEQ_DETECT_TIMEOUT_EN
    cfg(8'h1B, 4'd5, 1'b1, 8'd0, 16'd20);
    check("to_clear", bus.timeout, 0);
    for (int i = 0; i < 19; i++) beat(1'b0);
    check("to_busy19", bus.busy, 1);
    beat(1'b0);
    check("to_flag", bus.timeout, 1);
    check("to_done", bus.done, 0);
    check("to_busy", bus.busy, 0);
    cfg(8'h1B, 4'd5, 1'b1, 8'd0, 16'd20);
    check("to_restart", bus.timeout, 0);
    stream(32'b0000011011, 10, 1'b0, mv, gv);
    check("to_m10", mv, 32'h200);
    for (int i = 0; i < 19; i++) beat(1'b0);
    check("to_rb_busy", bus.busy, 1);
    check("to_rb_flag", bus.timeout, 0);
    beat(1'b0);
    check("to_rb_hit", bus.timeout, 1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/seq_detect_ctrl.md
Name: seq_detect_ctrl

Overview:
- Run-time programmable controller for the team's serial bit-pattern detectors. It generalises the fixed-pattern Moore detectors to a configurable pattern of 1..MAXLEN bits.
- Sequences a detection session: configure, arm, count matches, stop or finish on a target count.
- Sits between a host/config interface and a serial bit stream. Provides a registered (Moore-style) match pulse and a saturating match counter.

Parameters:
- MAXLEN, 8, maximum pattern length in bits.
- LENW, 4, width of cfg_len; must hold MAXLEN.
- CNTW, 8, width of match counter and target.
- TOW, 16, width of the timeout counter (used only with the optional feature).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- cfg_we  input  1  config write strobe; accepted in IDLE only.
- cfg_pattern  input  MAXLEN  pattern; bit [len-1] is the first bit received, bit [0] the last.
- cfg_len  input  LENW  pattern length; 0 or values >MAXLEN are clamped to MAXLEN.
- cfg_overlap  input  1  1 = overlapping detection, 0 = non-overlapping.
- cfg_target  input  CNTW  matches to finish on; 0 = run until stop.
- start  input  1  arm/start a session.
- stop  input  1  abort the session.
- in_valid  input  1  the serial bit is valid this cycle.
- in  input  1  serial data bit.
- busy  output  1  high in RUN.
- match  output  1  one-cycle registered pulse per detected pattern.
- done  output  1  high in DONE (target reached).
- match_count  output  CNTW  matches this session; saturates at all-ones.

Behaviour:
- Clock and reset are fixed: one clock, clk; reset rst is synchronous and active-high.
- Reset:
  - State goes to IDLE.
  - busy, match, done and match_count all go to 0.
  - Config registers reset to: pattern 0, len MAXLEN, overlap 1, target 0.
  - History shift register and fill counter are cleared.
  - Reset mid-session aborts it; all outputs are 0 on the next edge.
- States are IDLE, RUN and DONE.
- IDLE:
  - cfg_we latches all cfg_* fields.
  - start moves to RUN on the next edge and clears history, fill and match_count.
  - stop is ignored.
  - If cfg_we and start are high in the same cycle, the new config is latched and the session uses it.
- RUN:
  - busy=1. cfg_we and start are ignored.
  - On each in_valid beat, the bit shifts into the history at the LSB. The fill counter increments and saturates at len.
  - in_valid=0 holds the history.
  - A beat completes a match when both hold:
    - fill_before+1 >= len;
    - {history[len-2:0], in} equals pattern[len-1:0] over the low len bits.
  - On a match:
    - match is asserted for exactly one cycle, on the edge after the completing beat (latency 1).
    - match_count increments on that same edge, saturating.
  - overlap=0: the completing beat resets fill to 0, so the next match needs len fresh beats.
  - overlap=1: history is retained and suffix reuse is allowed.
  - Target: if target≠0 and match_count reaches target on an edge, the state goes to DONE on that same edge. match still pulses for that final match.
  - stop has priority over a beat in the same cycle. That beat is not evaluated, no match is produced, and the state goes to IDLE.
  - match_count is retained after stop until the next start.
- DONE:
  - done=1 and busy=0. Input beats are ignored.
  - start restarts the session as from IDLE.
  - stop goes to IDLE with done cleared.
  - match_count is held.
- len=1: every beat equal to pattern[0] is a match, in both overlap modes.

Optional Feature:
- Macro: SEQ_DETECT_TIMEOUT_EN.
- With the macro defined:
  - Adds input cfg_timeout[TOW-1:0], latched with the other config.
  - Adds output timeout (1 bit), held high until the next start or reset.
  - In RUN, a counter increments every clock cycle and clears on each match.
  - When cfg_timeout≠0 and the counter reaches cfg_timeout, the state goes to DONE with timeout=1; done stays 0 in this case.
  - cfg_timeout=0 disables the timeout.
- Without the macro: the port, the counter and the behaviour are all absent.

Test Plan:
1. Config pattern=5'b11011, len=5, overlap=1, target=0; start; stream 1,1,0,1,1,0,1,1 on consecutive beats -> match pulses the cycle after beat 5 and after beat 8; match_count=2; busy stays 1.
2. Same stream with overlap=0 -> single match after beat 5; match_count=1. Appending 0,1,1 gives a second match after beat 11.
3. Overlap=1, target=3; stream 1,1,0,1,1,0,1,1,0,1,1,1,1 -> third match after beat 11; done=1 and busy=0 on that edge; later beats do not change match_count (stays 3).
4. Scenario 1 stream with in_valid=0 inserted between every beat -> identical match_count=2. Each match is 1 cycle after its completing valid beat.
5. stop asserted together with beat 5 of 1,1,0,1,1 -> no match, IDLE next edge, match_count=0. Then rst mid-RUN -> busy, match, done and match_count all 0 next edge.
6. SEQ_DETECT_TIMEOUT_EN defined, cfg_timeout=20; start with a constant 0 stream -> timeout=1, done=0, busy=0 after 20 RUN cycles. A match at cycle 10 restarts the count.
